// File: rtl/main_memory_responder_pkg.sv
// Shared block geometry and FSM encodings for the main-memory responder and its cache-side peer.
package main_memory_responder_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_LATENCY     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/main_memory_responder_mem_word_array.sv
// Single-port word RAM: synchronous write, combinational read.
module mem_word_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; its contents must survive RST and a
    // resettable array could not be mapped onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Block refill/writeback responder behind the data cache: latency wait, one word per beat, one-cycle ready.
// Optional MEM_PERF_CNT_EN adds saturating read/write completion counters (RdCount, WrCount).
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                                        CLK,
    input  logic                                        RST,
    input  logic                                        MemReq,
    input  logic                                        MemWE,
    input  logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]       MemBlockAddr,
    input  logic [DATA_W*BLOCK_WORDS-1:0]               MemWriteBlock,
    output logic                                        MemBusy,
    output logic                                        MemReady,
    output logic [DATA_W*BLOCK_WORDS-1:0]               MemReadBlock
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [15:0]                                 RdCount,
    output logic [15:0]                                 WrCount
`endif
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int BA_W   = ADDR_W - BEAT_W;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef logic [BLOCK_WORDS-1:0][DATA_W-1:0] block_t;

    mem_state_e         state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               accept;
    logic               last_beat;

    logic               we_q;
    logic [BA_W-1:0]    blk_q;
    block_t             wblk_q;
    block_t             rbuf_q, rbuf_next;
    block_t             read_block_q;

    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
        end
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemReq) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = ST_BURST;
                        beat_d  = '0;
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_BURST: begin
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BLOCK_WORDS - 1)) begin
                    last_beat = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign MemBusy  = (state_q != ST_IDLE);
    assign MemReady = (state_q == ST_RESP);

    // Write-enable is not gated by RST: the beat in flight when reset arrives still lands.
    assign mem_we = (state_q == ST_BURST) && we_q;

    mem_word_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .addr  ({blk_q, beat_q}),
        .wdata (wblk_q[beat_q]),
        .rdata (mem_rdata)
    );

    always_comb begin
        rbuf_next         = rbuf_q;
        rbuf_next[beat_q] = mem_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q   <= MemWE;
            blk_q  <= MemBlockAddr;
            wblk_q <= MemWriteBlock;
        end
        if ((state_q == ST_BURST) && !we_q) begin
            rbuf_q <= rbuf_next;
        end
    end

    // The completed block is published on the edge into RESP so it is valid while MemReady is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            read_block_q <= '0;
        end else if (last_beat && !we_q) begin
            read_block_q <= rbuf_next;
        end
    end

    assign MemReadBlock = read_block_q;

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RdCount <= '0;
            WrCount <= '0;
        end else if (state_q == ST_RESP) begin
            if (we_q) begin
                WrCount <= sat_inc16(WrCount);
            end else begin
                RdCount <= sat_inc16(RdCount);
            end
        end
    end
`endif

endmodule
